// File: rtl/jts16_fd1089_keyload_pkg.sv
// jts16_fd1089_keyload_pkg: FSM states, key-type codes and default download addresses.
package jts16_fd1089_keyload_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN, ST_READY} state_t;
    typedef enum logic [1:0] {TY_NONE, TY_A, TY_B, TY_INV} ktype_t;

    localparam logic [21:0] KEY_START_DEF = 22'h0_0000;
    localparam logic [21:0] LUT_START_DEF = 22'h0_2000;
    localparam logic [21:0] TYPE_ADDR_DEF = 22'h0_2100;

    function automatic ktype_t decode_type(input logic [7:0] b);
        return b == 8'h00 ? TY_NONE : b == 8'h01 ? TY_A : b == 8'h02 ? TY_B : TY_INV;
    endfunction
endpackage

// File: rtl/jts16_fd1089_keyload_ram.sv
// jts16_fd1089_keyload_ram: simple dual-port RAM, write port plus registered read port.
module jts16_fd1089_keyload_ram #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else rdata <= mem[raddr];
    end
endmodule

// File: rtl/jts16_fd1089_keyload.sv
// jts16_fd1089_keyload: captures FD1089 key/LUT/type from the download stream,
// serves key bytes to the decoder and scans the key to decide dec_en/dec_type.
module jts16_fd1089_keyload
    import jts16_fd1089_keyload_pkg::*;
#(
    parameter logic [21:0] KEY_START = KEY_START_DEF,
    parameter logic [21:0] LUT_START = LUT_START_DEF,
    parameter logic [21:0] TYPE_ADDR = TYPE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] dwn_addr,
    input  logic [7:0]  dwn_data,
    input  logic        dwn_we,
    input  logic [12:0] key_addr,
    output logic [7:0]  key_data,
    output logic [7:0]  lut_addr,
    output logic [7:0]  lut_data,
    output logic        lut_we,
    output logic        dec_en,
    output logic        dec_type,
    output logic        key_ready,
    output logic        key_err
);
    state_t      state;
    ktype_t      ktype;
    logic        dl_prev, nz, rd_vld, scan_wrap;
    logic [12:0] scan_cnt;
    logic [8:0]  lut_cnt;
    logic [21:0] key_off, lut_off;
    logic        dl_rise, dl_fall, wr, key_hit, lut_hit, type_hit, err;

    assign key_off  = dwn_addr - KEY_START;
    assign lut_off  = dwn_addr - LUT_START;
    assign dl_rise  = downloading & ~dl_prev;
    assign dl_fall  = ~downloading & dl_prev;
    assign wr       = state == ST_LOAD && dwn_we;
    assign key_hit  = wr && key_off[21:13] == '0;
    assign lut_hit  = wr && lut_off[21:8] == '0;
    assign type_hit = wr && dwn_addr == TYPE_ADDR;
    assign err      = lut_cnt != 9'd256 || ktype == TY_INV;

    jts16_fd1089_keyload_ram #(.AW(13), .DW(8)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (key_hit),
        .waddr (key_off[12:0]),
        .wdata (dwn_data),
        .raddr (state == ST_SCAN ? scan_cnt : key_addr),
        .rdata (key_data)
    );

    // rd_vld marks that key_data holds a scan read; READY waits for it to drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ktype     <= TY_NONE;
            dl_prev   <= 1'b0;
            nz        <= 1'b0;
            rd_vld    <= 1'b0;
            scan_wrap <= 1'b0;
            scan_cnt  <= '0;
            lut_cnt   <= '0;
            lut_addr  <= '0;
            lut_data  <= '0;
            lut_we    <= 1'b0;
            dec_en    <= 1'b0;
            dec_type  <= 1'b0;
            key_ready <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            dl_prev <= downloading;
            lut_we  <= lut_hit;
            if (lut_hit) begin
                lut_addr <= lut_off[7:0];
                lut_data <= dwn_data;
            end
            if (lut_hit && lut_cnt != 9'd256) lut_cnt <= lut_cnt + 9'd1;
            if (type_hit) ktype <= decode_type(dwn_data);
            rd_vld <= state == ST_SCAN && !scan_wrap;
            if (rd_vld && key_data != '0) nz <= 1'b1;
            if (dl_rise) begin
                state     <= ST_LOAD;
                ktype     <= TY_NONE;
                nz        <= 1'b0;
                lut_cnt   <= '0;
                dec_en    <= 1'b0;
                key_ready <= 1'b0;
                key_err   <= 1'b0;
            end else if (state == ST_LOAD && dl_fall) begin
                state     <= ST_SCAN;
                scan_cnt  <= '0;
                scan_wrap <= 1'b0;
            end else if (state == ST_SCAN) begin
                if (!scan_wrap) begin
                    scan_cnt  <= scan_cnt + 13'd1;
                    scan_wrap <= &scan_cnt;
                end else if (!rd_vld) begin
                    state     <= ST_READY;
                    key_ready <= 1'b1;
                    key_err   <= err;
                    dec_en    <= nz && (ktype == TY_A || ktype == TY_B) && !err;
                    dec_type  <= ktype == TY_B;
                end
            end
        end
    end
endmodule
